// File: rtl/accum_16bit_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// accum_16bit_ctrl_if : sample/adder/result bundle of the accumulator.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface accum_16bit_ctrl_if #(
  parameter int CNT_WIDTH = 4
);
  logic                 clear;
  logic                 in_valid;
  logic [15:0]          in_data;
  logic                 in_ready;
  logic [15:0]          add_a;
  logic [15:0]          add_b;
  logic                 add_carry;
  logic [15:0]          add_sum;
  logic                 add_overflow;
  logic [15:0]          result;
  logic                 result_valid;
  logic                 result_ready;
  logic                 sticky_ovf;
  logic [CNT_WIDTH-1:0] sample_count;

  // The accumulator block side.
  modport slave (
    input  clear, in_valid, in_data, add_sum, add_overflow, result_ready,
    output in_ready, add_a, add_b, add_carry, result, result_valid,
           sticky_ovf, sample_count
  );

  // The environment side: sample source, external adder and result consumer.
  modport master (
    output clear, in_valid, in_data, add_sum, add_overflow, result_ready,
    input  in_ready, add_a, add_b, add_carry, result, result_valid,
           sticky_ovf, sample_count
  );
endinterface
`default_nettype wire

// File: rtl/accum_16bit_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// accum_16bit_ctrl : closes the loop around an external 16-bit adder and
//                    sums NUM_SAMPLES samples per valid/ready result.
// Revision: 1.0
// ---------------------------------------------------------------------------
module accum_16bit_ctrl #(
  parameter int NUM_SAMPLES = 8,
  parameter int CNT_WIDTH   = 4
) (
  input  wire logic        clk,
  input  wire logic        n_rst,
  accum_16bit_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_last_cnt = CNT_WIDTH'(NUM_SAMPLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [15:0]          acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sticky_q, sticky_d;

  logic w_in_ready;
  logic w_accept;

  assign w_in_ready = ~bus.clear & (state_q != DONE);
  assign w_accept   = bus.in_valid & w_in_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      acc_q    <= 16'h0000;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;

    // clear outranks accept and result handoff, and drops the offered sample.
    if (bus.clear) begin
      state_d  = IDLE;
      acc_d    = 16'h0000;
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (w_accept) begin
            acc_d    = bus.add_sum;
            sticky_d = sticky_q | bus.add_overflow;
            cnt_d    = cnt_q + c_cnt_one;
            state_d  = (cnt_q == c_last_cnt) ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            state_d  = IDLE;
            acc_d    = 16'h0000;
            cnt_d    = '0;
            sticky_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.add_a        = acc_q;
  assign bus.add_b        = bus.in_data;
  assign bus.add_carry    = 1'b0;
  assign bus.result       = acc_q;
  assign bus.result_valid = (state_q == DONE);
  assign bus.sticky_ovf   = sticky_q;
  assign bus.sample_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_accum_16bit_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_accum_16bit_ctrl : directed stimulus with a queued-expectation monitor.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_accum_16bit_ctrl;

  localparam int NUM_SAMPLES = 8;
  localparam int CNT_WIDTH   = 4;

  logic clk;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;
  logic [16:0] exp_q[$];

  accum_16bit_ctrl_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  accum_16bit_ctrl #(
    .NUM_SAMPLES(NUM_SAMPLES),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  // External combinational adder.
  logic [16:0] w_add_full;
  assign w_add_full       = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'h0000, bus.add_carry};
  assign bus.add_sum      = w_add_full[15:0];
  assign bus.add_overflow = w_add_full[16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per result handoff.
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (n_rst && bus.result_valid && bus.result_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got 0x%0h expected none", bus.result);
        end else begin
          e = exp_q.pop_front();
          chk("result", {16'h0, bus.result}, {16'h0, e[15:0]});
          chk("sticky_ovf", {31'h0, bus.sticky_ovf}, {31'h0, e[16]});
        end
      end
    end
  end

  // Entered and left at posedge+1; holds in_valid until accepted.
  task automatic send(input logic [15:0] d);
    int  n;
    logic acc;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    forever begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 20) begin
        chk("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_rst            = 1'b0;
    bus.clear        = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_data      = 16'h0000;
    bus.result_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;

    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
    chk("rst_result_valid", {31'h0, bus.result_valid}, 32'd0);
    chk("rst_count", {28'h0, bus.sample_count}, 32'd0);
    chk("rst_result", {16'h0, bus.result}, 32'd0);

    // Reset mid-batch after three samples.
    send(16'd1); send(16'd2); send(16'd3);
    chk("pre_rst_count", {28'h0, bus.sample_count}, 32'd3);
    chk("pre_rst_acc", {16'h0, bus.add_a}, 32'd6);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_acc", {16'h0, bus.add_a}, 32'd0);
    chk("midrst_count", {28'h0, bus.sample_count}, 32'd0);
    chk("midrst_result_valid", {31'h0, bus.result_valid}, 32'd0);
    chk("midrst_in_ready", {31'h0, bus.in_ready}, 32'd1);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back 1..8 -> 0x24.
    exp_q.push_back({1'b0, 16'h0024});
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) chk("b2b_valid_before_last", {31'h0, bus.result_valid}, 32'd0);
      send(16'(i));
    end
    chk("b2b_valid_after_last", {31'h0, bus.result_valid}, 32'd1);
    chk("b2b_in_ready_done", {31'h0, bus.in_ready}, 32'd0);
    idle(1);
    chk("b2b_back_idle", {31'h0, bus.result_valid}, 32'd0);
    chk("b2b_count_zero", {28'h0, bus.sample_count}, 32'd0);

    // Wrap: FFFF + 2 + six zeros -> 0x0001 with sticky overflow.
    exp_q.push_back({1'b1, 16'h0001});
    send(16'hFFFF);
    send(16'h0002);
    chk("wrap_sticky_mid", {31'h0, bus.sticky_ovf}, 32'd1);
    for (int i = 0; i < 6; i++) send(16'h0000);
    idle(2);

    // Backpressure: eight FFFF -> 0xFFF8 sticky, held for five cycles.
    bus.result_ready = 1'b0;
    exp_q.push_back({1'b1, 16'hFFF8});
    for (int i = 0; i < 8; i++) send(16'hFFFF);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h5555;
    repeat (5) begin
      @(negedge clk);
      chk("bp_result_stable", {16'h0, bus.result}, 32'hFFF8);
      chk("bp_in_ready", {31'h0, bus.in_ready}, 32'd0);
      chk("bp_valid", {31'h0, bus.result_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid     = 1'b0;
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", {31'h0, bus.result_valid}, 32'd0);
    chk("bp_release_acc", {16'h0, bus.add_a}, 32'd0);
    chk("bp_release_sticky", {31'h0, bus.sticky_ovf}, 32'd0);
    chk("bp_release_count", {28'h0, bus.sample_count}, 32'd0);

    // clear with a sample offered at count 3.
    send(16'd5); send(16'd6); send(16'd7);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0100;
    bus.clear    = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", {31'h0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_acc", {16'h0, bus.add_a}, 32'd0);
    chk("clr_count", {28'h0, bus.sample_count}, 32'd0);

    // Gapped 1..8 -> same 0x24; adder carry-in must stay low.
    exp_q.push_back({1'b0, 16'h0024});
    for (int i = 1; i <= 8; i++) begin
      bus.in_data = 16'(i * 3);
      #1;
      chk("gap_add_b", {16'h0, bus.add_b}, 32'(i * 3));
      chk("gap_add_carry", {31'h0, bus.add_carry}, 32'd0);
      send(16'(i));
      idle(1);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
